cu_prefetch_command_buffer: RTL and testbench
=============================================

Name: cu_prefetch_command_buffer

Overview:
- Sits directly downstream of the prefetch stream engine control.
- Accepts its CommandBufferLine stream into a FIFO and returns BufferStatus to it for alfull back-pressure.
- Issues buffered commands to the command arbiter on grant.
- Limits in-flight prefetch commands with a credit counter that is replenished by returning responses.

Parameters:
- DEPTH, 16, FIFO entries; power of 2, minimum 8.
- ALFULL_MARGIN, 4, free entries remaining when alfull asserts. Covers 3 upstream in-flight commands plus 1 spare.
- MAX_OUTSTANDING, 32, maximum issued commands awaiting response.
- CU_ID, PREFETCH_READ_CONTROL_ID, expected cmd.cu_id for responses that return credit.

Ports:
- clock, input, 1, sole clock; all logic on the rising edge.
- rstn, input, 1, synchronous active-low reset.
- enabled_in, input, 1, block enable; registered internally as enabled.
- command_in, input, CommandBufferLine, commands from the stream engine; push when .valid.
- command_arbiter_grant, input, 1, arbiter accepts the head command this cycle.
- response_in, input, ResponseBufferLine, completions; .valid with cmd.cu_id==CU_ID returns one credit.
- command_out, output, CommandBufferLine, issued command; registered, single-cycle .valid pulse.
- buffer_status, output, BufferStatus, fields valid/empty/full/alfull; registered.
- outstanding_count, output, $clog2(MAX_OUTSTANDING+1), commands issued minus credits returned.
- error_flags, output, 2, [0] overflow (push while full), [1] credit underflow; sticky until reset.

Behaviour:
- Reset: synchronous, sampled when rstn==0 at a clock edge. It clears FIFO pointers and count, enabled, command_out (all zero), outstanding_count=0 and error_flags=0. buffer_status resets to empty=1, valid=0, full=0, alfull=0.
- Reset mid-operation discards all entries and credits. No command_out pulse is produced in the cycle after reset.
- enabled:
  - Registered from enabled_in with 1-cycle lag.
  - When enabled==0, no push and no pop occur. Responses still return credits. State is held and command_out.valid=0.
- Push: enabled && command_in.valid && (count<DEPTH || pop this cycle). The entry is written at the edge.
- Overflow: command_in.valid while full and no pop. The command is dropped and error_flags[0] is set.
- Pop/issue condition: enabled && count!=0 && outstanding_count<MAX_OUTSTANDING && command_arbiter_grant.
  - Grant arriving without this condition is ignored.
  - On issue, command_out is loaded with the head entry (valid=1) at that edge. Otherwise command_out is cleared to 0 at the edge.
- Latency:
  - command_in.valid sampled at edge N → entry present and counted after N.
  - The earliest grant that can issue it is the one sampled at edge N+1.
  - command_out.valid is high during the cycle after edge N+1.
  - There is no bypass path.
- Simultaneous push+pop: count unchanged. Allowed when full (pop frees the slot). When empty, only the push takes effect.
- Pointers are log2(DEPTH) bits and wrap naturally. Count is log2(DEPTH)+1 bits.
- Credits:
  - outstanding_count +1 on issue, −1 on a credit-returning response; both in the same cycle leave it unchanged.
  - A response while outstanding_count==0 and no issue that cycle holds the count at 0 and sets error_flags[1].
  - At MAX_OUTSTANDING, issue stalls; FIFO continues accepting commands until full.
- buffer_status, registered from next-state values:
  - empty = next_count==0.
  - full = next_count==DEPTH.
  - alfull = next_count >= DEPTH−ALFULL_MARGIN.
  - valid = next_count!=0 && next_outstanding<MAX_OUTSTANDING.
- Ordering: strict FIFO. Entries are passed unmodified (address, size, abt, cmd fields).

Test Plan:
- Reset with enabled_in=1, single command_in (address 0x1000) at edge 2, grant held high → command_out.valid for exactly one cycle after edge 3 with address 0x1000; outstanding_count=1.
- Push 12 commands, grant=0 → buffer_status.alfull=1 after the 12th push and full=0. A 16th push sets full=1; a 17th push sets error_flags[0]=1 and count stays 16.
- Full FIFO, push+grant on the same edge → count stays 16, no overflow flag, output order is preserved (addresses 0,128,...,1920 then the new one).
- MAX_OUTSTANDING=32 reached, grant held → no further command_out and buffer_status.valid=0. One response with cu_id=CU_ID → exactly one more issue next grant.
- Response with outstanding_count=0 → error_flags[1]=1 and outstanding_count stays 0. Response with a foreign cu_id → no change.
- 8 commands buffered, rstn low for 1 edge mid-stream → empty=1, outstanding_count=0, command_out=0, no further issue until a new push.

Source files
------------

// File: rtl/cu_prefetch_command_buffer.sv
// Prefetch command buffer: FIFO between the stream engine and the command
// arbiter, with credit-limited issue and registered back-pressure status.

package cu_prefetch_command_buffer_pkg;

  localparam int unsigned ADDR_W  = 64;
  localparam int unsigned SIZE_W  = 32;
  localparam int unsigned ABT_W   = 4;
  localparam int unsigned CU_ID_W = 8;
  localparam int unsigned TAG_W   = 8;

  localparam logic [CU_ID_W-1:0] PREFETCH_READ_CONTROL_ID = 8'h21;

  typedef struct packed {
    logic [CU_ID_W-1:0] cu_id;
    logic [TAG_W-1:0]   tag;
  } cmd_meta_t;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] address;
    logic [SIZE_W-1:0] size;
    logic [ABT_W-1:0]  abt;
    cmd_meta_t         cmd;
  } command_buffer_line_t;

  typedef struct packed {
    logic      valid;
    cmd_meta_t cmd;
  } response_buffer_line_t;

  typedef struct packed {
    logic valid;
    logic empty;
    logic full;
    logic alfull;
  } buffer_status_t;

endpackage

module cu_prefetch_command_buffer
  import cu_prefetch_command_buffer_pkg::*;
#(
  parameter int unsigned         DEPTH           = 16,
  parameter int unsigned         ALFULL_MARGIN   = 4,
  parameter int unsigned         MAX_OUTSTANDING = 32,
  parameter logic [CU_ID_W-1:0]  CU_ID           = PREFETCH_READ_CONTROL_ID
) (
  input  logic                                     clock,
  input  logic                                     rstn,
  input  logic                                     enabled_in,
  input  command_buffer_line_t                     command_in,
  input  logic                                     command_arbiter_grant,
  input  response_buffer_line_t                    response_in,
  output command_buffer_line_t                     command_out,
  output buffer_status_t                           buffer_status,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]     outstanding_count,
  output logic [1:0]                               error_flags
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);

  command_buffer_line_t mem [DEPTH];

  logic          enabled;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic           pop;
  logic           push;
  logic           overflow;
  logic           credit;
  logic           underflow;
  logic [CW-1:0]  next_count;
  logic [OW-1:0]  next_outstanding;
  buffer_status_t next_status;

  // Tag bits of a response carry no meaning for credit return.
  logic unused_resp_tag;
  assign unused_resp_tag = ^response_in.cmd.tag;

  // Issue/accept decisions, credit arithmetic and next-cycle status.
  always_comb begin
    pop              = 1'b0;
    push             = 1'b0;
    overflow         = 1'b0;
    credit           = 1'b0;
    underflow        = 1'b0;
    next_count       = count;
    next_outstanding = outstanding_count;
    next_status      = '0;

    pop = enabled && (count != '0) &&
          (outstanding_count < OW'(MAX_OUTSTANDING)) && command_arbiter_grant;
    push     = enabled && command_in.valid && ((count < CW'(DEPTH)) || pop);
    overflow = enabled && command_in.valid && (count == CW'(DEPTH)) && !pop;
    credit   = response_in.valid && (response_in.cmd.cu_id == CU_ID);

    next_count = count + CW'(push) - CW'(pop);

    if (pop && !credit) begin
      next_outstanding = outstanding_count + OW'(1);
    end else if (!pop && credit) begin
      if (outstanding_count == '0) begin
        underflow = 1'b1;
      end else begin
        next_outstanding = outstanding_count - OW'(1);
      end
    end

    next_status.empty  = (next_count == '0);
    next_status.full   = (next_count == CW'(DEPTH));
    next_status.alfull = (next_count >= CW'(DEPTH - ALFULL_MARGIN));
    next_status.valid  = (next_count != '0) &&
                         (next_outstanding < OW'(MAX_OUTSTANDING));
  end

  // FIFO storage; stored lines always have valid set since only valid lines push.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= command_in;
    end
  end

  // Control state, issued command, credits and sticky errors.
  always_ff @(posedge clock) begin
    if (!rstn) begin
      enabled           <= 1'b0;
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      count             <= '0;
      command_out       <= '0;
      outstanding_count <= '0;
      error_flags       <= '0;
      buffer_status     <= '{valid: 1'b0, empty: 1'b1, full: 1'b0, alfull: 1'b0};
    end else begin
      enabled           <= enabled_in;
      count             <= next_count;
      outstanding_count <= next_outstanding;
      buffer_status     <= next_status;
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr      <= rd_ptr + AW'(1);
        command_out <= mem[rd_ptr];
      end else begin
        command_out <= '0;
      end
      if (overflow) begin
        error_flags[0] <= 1'b1;
      end
      if (underflow) begin
        error_flags[1] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cu_prefetch_command_buffer.sv
// Directed bench for cu_prefetch_command_buffer with a queue-based reference model.

module tb_cu_prefetch_command_buffer;
  import cu_prefetch_command_buffer_pkg::*;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned ALF   = 4;
  localparam int unsigned MAXO  = 32;

  logic                  clock = 1'b0;
  logic                  rstn;
  logic                  enabled_in;
  command_buffer_line_t  command_in;
  logic                  command_arbiter_grant;
  response_buffer_line_t response_in;
  command_buffer_line_t  command_out;
  buffer_status_t        buffer_status;
  logic [5:0]            outstanding_count;
  logic [1:0]            error_flags;

  int checks = 0;
  int errors = 0;
  bit checking = 1'b0;

  cu_prefetch_command_buffer #(
    .DEPTH(DEPTH), .ALFULL_MARGIN(ALF), .MAX_OUTSTANDING(MAXO),
    .CU_ID(PREFETCH_READ_CONTROL_ID)
  ) dut (
    .clock(clock), .rstn(rstn), .enabled_in(enabled_in),
    .command_in(command_in), .command_arbiter_grant(command_arbiter_grant),
    .response_in(response_in), .command_out(command_out),
    .buffer_status(buffer_status), .outstanding_count(outstanding_count),
    .error_flags(error_flags)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic command_buffer_line_t mk(input logic [63:0] a);
    command_buffer_line_t c;
    c = '0;
    c.valid     = 1'b1;
    c.address   = a;
    c.size      = 32'd64;
    c.abt       = 4'h2;
    c.cmd.cu_id = PREFETCH_READ_CONTROL_ID;
    c.cmd.tag   = a[14:7];
    return c;
  endfunction

  // Reference model: a queue of buffered commands and an integer credit count.
  command_buffer_line_t mq[$];
  int                   m_out;
  bit                   m_en;
  command_buffer_line_t m_cmd;
  buffer_status_t       m_st;
  logic [1:0]           m_err;
  bit                   m_issue;
  bit                   m_credit;

  always @(posedge clock) begin
    if (!rstn) begin
      mq.delete();
      m_out = 0;
      m_en  = 1'b0;
      m_cmd = '0;
      m_err = 2'b00;
      m_st  = '{valid: 1'b0, empty: 1'b1, full: 1'b0, alfull: 1'b0};
    end else begin
      m_issue  = m_en && (mq.size() > 0) && (m_out < MAXO) && command_arbiter_grant;
      m_credit = response_in.valid && (response_in.cmd.cu_id == PREFETCH_READ_CONTROL_ID);
      m_cmd = '0;
      if (m_issue) m_cmd = mq.pop_front();
      if (m_en && command_in.valid) begin
        if (mq.size() < DEPTH) mq.push_back(command_in);
        else m_err[0] = 1'b1;
      end
      if (m_issue) m_out++;
      if (m_credit) begin
        if (m_out > 0) m_out--;
        else m_err[1] = 1'b1;
      end
      m_st.empty  = (mq.size() == 0);
      m_st.full   = (mq.size() == DEPTH);
      m_st.alfull = (mq.size() >= DEPTH - ALF);
      m_st.valid  = (mq.size() != 0) && (m_out < MAXO);
      m_en = enabled_in;
    end
  end

  // Compare every cycle once the design has been reset.
  always @(negedge clock) begin
    if (checking) begin
      chk("command_out", 128'(command_out), 128'(m_cmd));
      chk("buffer_status", 128'(buffer_status), 128'(m_st));
      chk("outstanding_count", 128'(outstanding_count), 128'(m_out));
      chk("error_flags", 128'(error_flags), 128'(m_err));
    end
  end

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
  endtask

  initial begin
    rstn = 1'b0;
    enabled_in = 1'b1;
    command_arbiter_grant = 1'b0;
    command_in = '0;
    response_in = '0;
    tick();
    tick();
    checking = 1'b1;
    chk("reset_status", 128'(buffer_status), 128'(4'b0100));
    chk("reset_outstanding", 128'(outstanding_count), 128'(0));
    chk("reset_command_out", 128'(command_out), 128'(0));

    // Single command: push at edge N, issue at N+1, one-cycle pulse.
    rstn = 1'b1;
    tick();
    command_in = mk(64'h1000);
    command_arbiter_grant = 1'b1;
    tick();
    command_in = '0;
    chk("t1_no_bypass", 128'(command_out.valid), 128'(0));
    tick();
    chk("t1_issue_valid", 128'(command_out.valid), 128'(1));
    chk("t1_issue_addr", 128'(command_out.address), 128'(64'h1000));
    chk("t1_outstanding", 128'(outstanding_count), 128'(1));
    command_arbiter_grant = 1'b0;
    tick();
    chk("t1_pulse_ends", 128'(command_out.valid), 128'(0));
    response_in.valid = 1'b1;
    response_in.cmd.cu_id = PREFETCH_READ_CONTROL_ID;
    tick();
    response_in = '0;
    chk("t1_credit_back", 128'(outstanding_count), 128'(0));

    // Fill to alfull, full, then overflow.
    for (int i = 0; i < 17; i++) begin
      command_in = (i == 16) ? mk(64'hDEAD00) : mk(64'(i * 128));
      tick();
      if (i == 11) begin
        chk("t2_alfull_at_12", 128'(buffer_status.alfull), 128'(1));
        chk("t2_not_full_at_12", 128'(buffer_status.full), 128'(0));
      end
      if (i == 15) chk("t2_full_at_16", 128'(buffer_status.full), 128'(1));
    end
    chk("t2_overflow_flag", 128'(error_flags), 128'(2'b01));
    chk("t2_still_full", 128'(buffer_status.full), 128'(1));

    // Push and grant on the same edge while full, then drain in order.
    command_in = mk(64'h9000);
    command_arbiter_grant = 1'b1;
    for (int k = 0; k < 17; k++) begin
      tick();
      command_in = '0;
      if (k == 0) chk("t3_full_after_pushpop", 128'(buffer_status.full), 128'(1));
      chk("t3_order", 128'(command_out.address), (k < 16) ? 128'(k * 128) : 128'(64'h9000));
    end
    chk("t3_outstanding", 128'(outstanding_count), 128'(17));
    command_arbiter_grant = 1'b0;
    tick();

    // Credit limit stalls issue; one credit allows exactly one more.
    do_reset();
    command_arbiter_grant = 1'b1;
    for (int i = 0; i < 34; i++) begin
      command_in = mk(64'h20000 + 64'(i * 64));
      tick();
    end
    command_in = '0;
    repeat (3) tick();
    chk("t4_at_max", 128'(outstanding_count), 128'(32));
    chk("t4_stalled", 128'(command_out.valid), 128'(0));
    chk("t4_status_invalid", 128'(buffer_status.valid), 128'(0));
    chk("t4_not_empty", 128'(buffer_status.empty), 128'(0));
    response_in.valid = 1'b1;
    response_in.cmd.cu_id = PREFETCH_READ_CONTROL_ID;
    tick();
    response_in = '0;
    chk("t4_credit_returned", 128'(outstanding_count), 128'(31));
    chk("t4_no_issue_same_edge", 128'(command_out.valid), 128'(0));
    tick();
    chk("t4_one_more_issue", 128'(command_out.valid), 128'(1));
    chk("t4_one_more_addr", 128'(command_out.address), 128'(64'h20000 + 64'(32 * 64)));
    tick();
    chk("t4_stalls_again", 128'(command_out.valid), 128'(0));

    // Disabled: no push/pop, credits still return.
    enabled_in = 1'b0;
    tick();
    response_in.valid = 1'b1;
    response_in.cmd.cu_id = PREFETCH_READ_CONTROL_ID;
    tick();
    response_in = '0;
    chk("t5_disabled_credit", 128'(outstanding_count), 128'(31));
    chk("t5_disabled_no_issue", 128'(command_out.valid), 128'(0));
    command_in = mk(64'h7700);
    tick();
    command_in = '0;
    enabled_in = 1'b1;
    tick();
    tick();
    chk("t5_reenabled_issue", 128'(command_out.address), 128'(64'h20000 + 64'(33 * 64)));
    tick();
    chk("t5_dropped_while_disabled", 128'(buffer_status.empty), 128'(1));
    command_arbiter_grant = 1'b0;

    // Credit underflow and foreign responses.
    do_reset();
    response_in.valid = 1'b1;
    response_in.cmd.cu_id = PREFETCH_READ_CONTROL_ID;
    tick();
    chk("t6_underflow_flag", 128'(error_flags), 128'(2'b10));
    chk("t6_underflow_hold", 128'(outstanding_count), 128'(0));
    response_in.cmd.cu_id = ~PREFETCH_READ_CONTROL_ID;
    tick();
    response_in = '0;
    chk("t6_foreign_flags", 128'(error_flags), 128'(2'b10));
    command_in = mk(64'h3000);
    command_arbiter_grant = 1'b1;
    tick();
    command_in = '0;
    tick();
    command_arbiter_grant = 1'b0;
    response_in.valid = 1'b1;
    response_in.cmd.cu_id = ~PREFETCH_READ_CONTROL_ID;
    tick();
    response_in = '0;
    chk("t6_foreign_no_credit", 128'(outstanding_count), 128'(1));

    // Reset mid-stream with 8 entries buffered.
    for (int i = 0; i < 8; i++) begin
      command_in = mk(64'h50000 + 64'(i * 128));
      tick();
    end
    command_in = '0;
    command_arbiter_grant = 1'b1;
    rstn = 1'b0;
    tick();
    chk("t7_empty", 128'(buffer_status.empty), 128'(1));
    chk("t7_outstanding", 128'(outstanding_count), 128'(0));
    chk("t7_command_out", 128'(command_out), 128'(0));
    rstn = 1'b1;
    repeat (3) tick();
    chk("t7_no_issue", 128'(command_out.valid), 128'(0));
    command_in = mk(64'h4000);
    tick();
    command_in = '0;
    tick();
    chk("t7_new_issue", 128'(command_out.address), 128'(64'h4000));
    command_arbiter_grant = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
